// File: rtl/tff_pkg.sv
// Shared types and default constants for the toggle pulse path.
package tff_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level; flops clear to 0 on reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_pulse_gen.sv
// Synchronises and debounces a raw button, emitting one t_pulse per accepted press.
// Optional TOGGLE_REPEAT_EN adds auto-repeat pulses every REPEAT_CYCLES while held.
//
// state     | meaning
// LOW       | debounced level 0, idle
// WAIT_HIGH | candidate press, counting consecutive synced highs
// HIGH      | debounced level 1
// WAIT_LOW  | candidate release, counting consecutive synced lows
module toggle_pulse_gen
  import tff_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 8,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic             en,
  output logic             t_pulse,
  output logic             btn_level,
  output logic [CNT_W-1:0] pulse_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic s;
  state_t state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic pulse_q, pulse_d;
  logic level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic accept_rise;
  logic rep_fire;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_raw),
    .q_o   (s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept_rise = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = DW'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = HIGH;
          cnt_d       = '0;
          accept_rise = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = DW'(1);
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef TOGGLE_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q, rep_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_q <= '0;
    else       rep_q <= rep_d;
  end

  // Counts only while HIGH persists; any exit (even a bounce into WAIT_LOW) clears it.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (state_q == HIGH && s) begin
      if (rep_q == REP_LAST) rep_fire = 1'b1;
      else                   rep_d    = rep_q + RW'(1);
    end
  end
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    pulse_d = en & (accept_rise | rep_fire);
    level_d = (state_d == HIGH) || (state_d == WAIT_LOW);
    count_d = pulse_d ? count_q + CNT_W'(1) : count_q;
  end

  assign t_pulse     = pulse_q;
  assign btn_level   = level_q;
  assign pulse_count = count_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed bench for toggle_pulse_gen (CNT_W=2, REPEAT_CYCLES=50 for the optional repeat build).
module tb_toggle_pulse_gen;

  localparam int CNT_W = 2;
  localparam int LAT   = 18;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic en = 1'b1;
  logic t_pulse, btn_level;
  logic [CNT_W-1:0] pulse_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  int cyc, rise_at, fall_at, pulse_at, npulses, back_to_back;
  logic lvl_prev, pulse_prev;

  toggle_pulse_gen #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .CNT_W(CNT_W), .REPEAT_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .en(en),
    .t_pulse(t_pulse), .btn_level(btn_level), .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    cyc = 0; rise_at = -1; fall_at = -1; pulse_at = -1; npulses = 0;
    lvl_prev = btn_level; pulse_prev = t_pulse;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cyc++;
      if (t_pulse) begin
        npulses++;
        if (pulse_at < 0) pulse_at = cyc;
        if (pulse_prev) back_to_back++;
      end
      if (btn_level && !lvl_prev && rise_at < 0) rise_at = cyc;
      if (!btn_level && lvl_prev && fall_at < 0) fall_at = cyc;
      lvl_prev = btn_level;
      pulse_prev = t_pulse;
    end
  endtask

  task automatic press_release(input string tag, input int exp_pulses);
    mark();
    btn_raw = 1'b1;
    step(40);
    exp_cnt = (exp_cnt + exp_pulses) % (1 << CNT_W);
    chk({tag, "_pulses"}, npulses, exp_pulses);
    chk({tag, "_count"}, int'(pulse_count), exp_cnt);
    mark();
    btn_raw = 1'b0;
    step(30);
    chk({tag, "_rel_pulses"}, npulses, 0);
  endtask

  initial begin
    back_to_back = 0;
    repeat (3) tick();
    chk("rst_pulse", int'(t_pulse), 0);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_count", int'(pulse_count), 0);
    reset = 1'b0;
    step(5);

    // clean press
    mark();
    btn_raw = 1'b1;
    step(40);
    chk("clean_rise_lat", rise_at, LAT);
    chk("clean_pulse_lat", pulse_at, LAT);
    chk("clean_npulses", npulses, 1);
    chk("clean_count", int'(pulse_count), 1);
    exp_cnt = 1;
    mark();
    btn_raw = 1'b0;
    step(30);
    chk("clean_fall_lat", fall_at, LAT);
    chk("clean_rel_pulses", npulses, 0);

    // bounce: three 5-cycle highs separated by 3-cycle lows, then a steady hold
    mark();
    for (int r = 0; r < 3; r++) begin
      btn_raw = 1'b1; step(5);
      btn_raw = 1'b0; step(3);
    end
    btn_raw = 1'b1;
    step(40);
    chk("bounce_rise_lat", rise_at, 24 + LAT);
    chk("bounce_npulses", npulses, 1);
    exp_cnt = 2;
    chk("bounce_count", int'(pulse_count), exp_cnt);
    btn_raw = 1'b0;
    step(30);

    // enable gating
    en = 1'b0;
    mark();
    btn_raw = 1'b1;
    step(40);
    chk("en0_level", int'(btn_level), 1);
    chk("en0_npulses", npulses, 0);
    chk("en0_count", int'(pulse_count), exp_cnt);
    btn_raw = 1'b0;
    step(30);
    en = 1'b1;
    press_release("en1", 1);

    // counter wrap from a fresh reset: 1,2,3,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    step(3);
    chk("wrap_start", int'(pulse_count), 0);
    for (int p = 0; p < 5; p++) press_release($sformatf("wrap%0d", p), 1);
    chk("wrap_final", int'(pulse_count), 1);

    // reset in the middle of debouncing with the button still held
    mark();
    btn_raw = 1'b1;
    step(12);
    chk("mid_no_level", int'(btn_level), 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_pulse", int'(t_pulse), 0);
      chk("midrst_level", int'(btn_level), 0);
      chk("midrst_count", int'(pulse_count), 0);
    end
    reset = 1'b0;
    exp_cnt = 0;
    mark();
    step(40);
    chk("midrst_pulse_lat", pulse_at, LAT);
    chk("midrst_rise_lat", rise_at, LAT);
    chk("midrst_npulses", npulses, 1);
    chk("midrst_count", int'(pulse_count), 1);
    exp_cnt = 1;
    btn_raw = 1'b0;
    step(30);

    // long hold: auto-repeat at +0,+50,+100,+150 when enabled, otherwise a single pulse
    mark();
    btn_raw = 1'b1;
    step(LAT + 170);
`ifdef TOGGLE_REPEAT_EN
    chk("hold_npulses", npulses, 4);
    exp_cnt = (exp_cnt + 4) % (1 << CNT_W);
`else
    chk("hold_npulses", npulses, 1);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
`endif
    chk("hold_first_pulse", pulse_at, LAT);
    chk("hold_count", int'(pulse_count), exp_cnt);
    btn_raw = 1'b0;
    step(30);

    chk("no_back_to_back", back_to_back, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_pulse_gen.md
Name: toggle_pulse_gen

Overview:
Upstream conditioning stage for the T flip-flop. It takes a raw, asynchronous, bouncing push-button/switch level and synchronises and debounces it. It then emits exactly one single-cycle toggle pulse per accepted press, and that pulse drives the flip-flop's T input directly in the same clk domain. It also exports the debounced level and a pulse counter for status/visibility.

Parameters:
SYNC_STAGES, 2, flops in input synchroniser chain; legal range >= 2
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required to accept a level change; legal range >= 2
CNT_W, 8, width of pulse_count
REPEAT_CYCLES, 1000, auto-repeat period in cycles; used only with TOGGLE_REPEAT_EN; legal range >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
btn_raw  input  1  raw asynchronous button level, 1 = pressed
en  input  1  pulse enable; 0 suppresses t_pulse and counting, debouncing continues
t_pulse  output  1  registered one-cycle toggle pulse, feeds T input of the flip-flop
btn_level  output  1  registered debounced button level
pulse_count  output  CNT_W  number of t_pulse assertions since reset, wraps

Behaviour:
- Reset: clock and reset are clk and reset (reset asynchronous, active-high). Reset clears synchroniser flops, state=LOW, debounce counter=0, t_pulse=0, btn_level=0, pulse_count=0.
- Synchroniser: btn_raw passes through SYNC_STAGES flops; the last flop output is s. No other logic samples btn_raw.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES); it never exceeds DEBOUNCE_CYCLES-1.
- FSM states LOW, WAIT_HIGH, HIGH, WAIT_LOW:
  - LOW: s=1 -> WAIT_HIGH, cnt=1; else stay.
  - WAIT_HIGH: s=0 -> LOW, cnt=0 (bounce rejected). s=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH. s=1 otherwise -> cnt+1.
  - HIGH: s=0 -> WAIT_LOW, cnt=1; else stay.
  - WAIT_LOW: mirror of WAIT_HIGH, with s=1 -> HIGH and acceptance -> LOW.
- Timing: if s is first 1 at cycle k and stays 1 through k+DEBOUNCE_CYCLES-1, then btn_level=1 from cycle k+DEBOUNCE_CYCLES. Release is symmetric.
- End-to-end latency from btn_raw edge to btn_level is SYNC_STAGES+DEBOUNCE_CYCLES clk edges (18 with defaults).
- t_pulse: asserted for exactly the cycle btn_level first becomes 1 (LOW->HIGH acceptance), provided en=1 in the cycle of the WAIT_HIGH->HIGH decision. A release never produces a pulse.
- pulse_count increments by 1, modulo 2^CNT_W, in the same cycle t_pulse is 1; wraps from all-ones to 0 silently.
- en=0: state, cnt and btn_level evolve normally; t_pulse stays 0; pulse_count holds. A press accepted while en=0 is lost, not deferred.
- Held input at reset release: btn_raw=1 across reset deassertion is treated as a new press; one t_pulse occurs SYNC_STAGES+DEBOUNCE_CYCLES cycles after release.
- Reset mid-debounce discards partial count; no pulse is emitted for the interrupted press.
- t_pulse is never asserted on two consecutive cycles.

Optional Feature:
TOGGLE_REPEAT_EN:
- Defined: while in HIGH, a repeat counter runs. Additional t_pulse occur at HIGH-entry+REPEAT_CYCLES, +2*REPEAT_CYCLES, and so on, each gated by en and each counted in pulse_count.
- The repeat counter clears on leaving HIGH, including into WAIT_LOW, and on reset. A bounce to WAIT_LOW and back restarts the period.
- Undefined: the repeat counter and its logic are absent; exactly one pulse per press.

Decomposition:
- Package tff_pkg: state typedef enum logic[1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW}; shared default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
- One sub-module, bit_synchronizer (parameter STAGES, async reset to 0), instantiated once for btn_raw. It is reusable by other blocks in the codebase.

Test Plan:
- Clean press: reset, then btn_raw 0->1 held 40 cycles with en=1 -> btn_level rises 18 cycles after the edge; t_pulse high exactly 1 cycle, coincident with that rise; pulse_count=1; release gives no pulse.
- Bounce rejection: btn_raw toggled high/low with high runs of 5 cycles, then held high -> btn_level rises only after 16 consecutive synced highs; exactly one t_pulse.
- Enable gating: press with en=0 -> btn_level=1, t_pulse never 1, pulse_count=0. Release, then press with en=1 -> pulse_count=1.
- Counter wrap (CNT_W=2): 5 clean presses -> pulse_count sequence 1,2,3,0,1.
- Reset mid-debounce: press, assert reset at cycle 10 of WAIT_HIGH for 3 cycles, keep btn_raw high -> all outputs 0 during reset; one t_pulse 18 cycles after reset release.
- With TOGGLE_REPEAT_EN, REPEAT_CYCLES=50: hold 170 cycles after acceptance -> pulses at +0, +50, +100, +150; pulse_count=4.
